pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable, flush and bubble controls. It resolves three hazard sources:
- load-use data hazards,
- taken branches and jumps,
- a variable-latency data memory handshake, with a timeout watchdog.
It also keeps saturating stall and flush event counters for performance debug.

Parameters:
REG_W, 5, register-specifier width
MAX_MEM_WAIT, 16, consecutive frozen cycles without mem_ack before timeout error (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
id_rs  in  REG_W  rs field of instruction in ID
id_rt  in  REG_W  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_jump  in  2  Jump code decoded in ID: 00 none, 01 j, 10 jal, 11 jr
ex_mem_read  in  2  MemRead code of instruction in EX: 00 none, 01 lw, 10 lb, 11 lh
ex_rt  in  REG_W  destination rt of instruction in EX
ex_branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  MEM stage holds a load/store (MemRead!=0 or MemWrite!=0)
mem_ack  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID cleared to NOP on next edge
idex_write  out  1  ID/EX register enable
idex_bubble  out  1  ID/EX loaded with all-zero control (NOP)
exmem_hold  out  1  EX/MEM and MEM/WB hold current contents
mem_timeout_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
flush_events  out  CNT_W  saturating count of cycles with ifid_flush=1

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. The state register is updated only on rising clk.
- Reset (synchronous):
  - next state is RUN; wait_cnt, stall_cycles, flush_events and mem_timeout_err are cleared to 0.
  - While reset=1, outputs are forced: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, mem_timeout_err=0.
  - Reset asserted mid-MEM_WAIT or in ERR returns the FSM to RUN on the next edge.
- freeze = (RUN and mem_req and !mem_ack) or (MEM_WAIT and !mem_ack) or ERR.
- load_use = ex_mem_read!=00 and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
- Output priority, highest first (controls are combinational from state and inputs):
  - 1. freeze: pc_write=0, ifid_write=0, idex_write=0, exmem_hold=1, ifid_flush=0, idex_bubble=0. All stages hold; ex_branch_taken and id_jump are acted on after release.
  - 2. ex_branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1. Both younger instructions are squashed; a coincident load_use or id_jump is ignored.
  - 3. load_use: pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. The load then advances to MEM and the hazard clears. Jump in ID is deferred.
  - 4. id_jump!=00: pc_write=1, ifid_flush=1, one cycle.
  - 5. Otherwise all enables are 1 and flush/bubble/hold are 0.
- Memory handshake:
  - An ack in the same cycle as req gives zero stall.
  - RUN with mem_req and !mem_ack: go to MEM_WAIT and set wait_cnt=1.
  - MEM_WAIT with mem_ack: the pipeline advances in that cycle; go to RUN.
  - MEM_WAIT with !mem_ack: if wait_cnt+1==MAX_MEM_WAIT go to ERR, else wait_cnt increments.
- ERR: all stages frozen; mem_timeout_err=1 until reset; mem_ack is ignored.
- Counters:
  - Increment when reset=0 and the state is not ERR.
  - Saturate at all-ones; no wrap.
  - stall_cycles counts both freeze and load_use cycles.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding: RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10;
  - MemRead codes: MR_NONE, MR_LW, MR_LB, MR_LH;
  - Jump codes: J_NONE, J_J, J_JAL, J_JR.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count), is instantiated twice.

Test Plan:
- Reset held 3 cycles, then released with no hazards -> during reset pc_write=0, ifid_flush=1, idex_bubble=1; the first cycle after release has all enables=1 and counters=0.
- ex_mem_read=01, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- ex_branch_taken=1 together with load_use and id_jump=01 -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_events increments by 1.
- mem_req=1, mem_ack low for 3 cycles, then high -> 3 frozen cycles with exmem_hold=1 and ack-cycle enables=1; FSM back in RUN; stall_cycles=3.
- MAX_MEM_WAIT=4, mem_req=1, mem_ack never -> frozen cycles 1-4; mem_timeout_err=1 from cycle 5 and stays high with a later ack; reset clears it and counters stop incrementing in ERR.
- id_jump=11 during a memory freeze -> no flush while frozen; ifid_flush=1 in the cycle mem_ack arrives.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MR_NONE = 2'b00,
        MR_LW   = 2'b01,
        MR_LB   = 2'b10,
        MR_LH   = 2'b11
    } mem_read_t;

    typedef enum logic [1:0] {
        J_NONE = 2'b00,
        J_J    = 2'b01,
        J_JAL  = 2'b10,
        J_JR   = 2'b11
    } jump_t;

    // True when the EX-stage instruction is any flavour of load.
    function automatic logic is_load(input logic [1:0] mem_read);
        return mem_read_t'(mem_read) != MR_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// branch/jump squashing, and a variable-latency data memory freeze
// with a timeout watchdog plus saturating performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int MAX_MEM_WAIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [1:0]       id_jump,
    input  logic [1:0]       ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCW = $clog2(MAX_MEM_WAIT + 1);

    state_t         state;
    state_t         state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_nxt;
    logic           freeze;
    logic           load_use;
    logic           count_en;
    logic           stall_inc;
    logic           flush_inc;

    assign freeze = ((state == RUN) && mem_req && !mem_ack) ||
                    ((state == MEM_WAIT) && !mem_ack) ||
                    (state == ERR);

    assign load_use = is_load(ex_mem_read) && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State register and memory-wait cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Memory handshake tracking: enter wait on an unacked request, time out
    // after MAX_MEM_WAIT consecutive frozen cycles.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if ((wait_cnt + 1'b1) == WCW'(MAX_MEM_WAIT)) begin
                    state_nxt = ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Pipeline register controls, highest-priority hazard wins.
    always_comb begin
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        idex_write      = 1'b1;
        idex_bubble     = 1'b0;
        exmem_hold      = 1'b0;
        mem_timeout_err = !reset && (state == ERR);
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            exmem_hold = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (jump_t'(id_jump) != J_NONE) begin
            ifid_flush = 1'b1;
        end
    end

    assign count_en  = !reset && (state != ERR);
    assign stall_inc = count_en && !pc_write;
    assign flush_inc = count_en && ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by random traffic, all compared against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int MAXW  = 4;
    localparam int CW    = 5;
    localparam int SAT   = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt;
    logic [1:0]       id_jump, ex_mem_read;
    logic             ex_branch_taken, mem_req, mem_ack;
    logic             pc_write, ifid_write, ifid_flush, idex_write;
    logic             idex_bubble, exmem_hold, mem_timeout_err;
    logic [CW-1:0]    stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_W        (REG_W),
        .MAX_MEM_WAIT (MAXW),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_bubble     (idex_bubble),
        .exmem_hold      (exmem_hold),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: how many consecutive cycles the current memory
    // access has kept the pipe frozen, whether it has timed out, and
    // the two event tallies.
    int m_frozen_run = 0;
    bit m_timed_out  = 1'b0;
    int m_stall      = 0;
    int m_flush      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controls packed as {pc_write, ifid_write, ifid_flush, idex_write,
    // idex_bubble, exmem_hold, mem_timeout_err}.
    task automatic cyc(input bit rst, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input bit urt, input logic [1:0] jmp, input logic [1:0] mr,
                       input logic [REG_W-1:0] ert, input bit br, input bit req, input bit ack);
        logic [6:0] exp;
        logic [6:0] got;
        bit         frz;
        bit         lu;
        @(negedge clk);
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_jump = jmp;
        ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br; mem_req = req; mem_ack = ack;
        #1;
        frz = m_timed_out || (!ack && (req || m_frozen_run > 0));
        lu  = (mr != 2'b00) && (ert != 0) && (ert == rs || (urt && ert == rt));
        if (rst)          exp = 7'b0010100;
        else if (frz)     exp = {6'b000001, m_timed_out};
        else if (br)      exp = 7'b1111100;
        else if (lu)      exp = 7'b0001100;
        else if (jmp != 0) exp = 7'b1111000;
        else              exp = 7'b1101000;
        got = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold, mem_timeout_err};
        check("ctrl", 32'(got), 32'(exp));
        check("stall_cycles", 32'(stall_cycles), m_stall);
        check("flush_events", 32'(flush_events), m_flush);
        @(posedge clk);
        if (rst) begin
            m_frozen_run = 0; m_timed_out = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (!m_timed_out) begin
                if (!exp[6] && m_stall < SAT) m_stall++;
                if (exp[4] && m_flush < SAT) m_flush++;
            end
            if (frz && !m_timed_out) begin
                m_frozen_run++;
                if (m_frozen_run == MAXW) m_timed_out = 1'b1;
            end else if (!frz) begin
                m_frozen_run = 0;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_jump = 2'b00;
        ex_mem_read = 2'b00; ex_rt = '0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

        // Reset for 3 cycles, then a hazard-free cycle.
        repeat (3) do_reset();
        idle();

        // Load-use on rs, then the same with ex_rt=0 (no stall).
        cyc(0, 8, 0, 0, 2'b00, 2'b01, 8, 0, 0, 0);
        idle();
        #1 check("lu_stall_count", 32'(stall_cycles), 1);
        cyc(0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
        cyc(0, 3, 9, 1, 2'b00, 2'b11, 9, 0, 0, 0);

        // Taken branch overrides load-use and jump.
        cyc(0, 8, 0, 0, 2'b01, 2'b01, 8, 1, 0, 0);
        idle();

        // Memory wait of 3 cycles, then ack.
        do_reset();
        repeat (3) cyc(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
        #1 check("mem_wait_stall_count", 32'(stall_cycles), 3);
        idle();

        // Timeout: never ack, then a late ack is ignored; reset clears.
        do_reset();
        repeat (MAXW) cyc(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 2'b01, 2'b00, 0, 1, 0, 1);
        #1 check("timeout_sticky", 32'(mem_timeout_err), 1);
        do_reset();
        #1 check("timeout_cleared", 32'(mem_timeout_err), 0);

        // Jump register held during a memory freeze; flush on the ack cycle.
        repeat (2) cyc(0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 1, 1);
        idle();

        // Random traffic with small register fields to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) < 2),
                REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                1'($urandom), 2'(($urandom_range(0, 99) < 20) ? $urandom_range(1, 3) : 0),
                2'($urandom), REG_W'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 40),
                ($urandom_range(0, 99) < 45));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
